// File: rtl/cache_6502_nway_if.sv
// ============================================================================
// Module   : cache_6502_nway_if
// Purpose  : CPU-side and memory-side bus bundle for cache_6502_nway.
//            'slave' is the cache's view; 'master' is the view of the
//            environment (CPU core plus memory port) that surrounds it.
// Signals  : flush, cpu_* (CPU request/response), mem_* (24-bit memory
//            port), hit_count / miss_count (statistics).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface cache_6502_nway_if;
    logic        flush;
    logic [15:0] cpu_addr;
    logic        cpu_en;
    logic        cpu_wr;
    logic        cpu_iread;
    logic [7:0]  cpu_wdata;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic [23:0] mem_addr;
    logic        mem_en;
    logic        mem_wr;
    logic        mem_rburst;
    logic        mem_wburst;
    logic [7:0]  mem_wdata;
    logic        mem_rdy;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_rdata0;
    logic        mem_rdata_load;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    modport slave (
        input  flush, cpu_addr, cpu_en, cpu_wr, cpu_iread, cpu_wdata,
        output cpu_rdy, cpu_rdata,
        output mem_addr, mem_en, mem_wr, mem_rburst, mem_wburst, mem_wdata,
        input  mem_rdy, mem_rdata, mem_rdata0, mem_rdata_load,
        output hit_count, miss_count
    );

    modport master (
        output flush, cpu_addr, cpu_en, cpu_wr, cpu_iread, cpu_wdata,
        input  cpu_rdy, cpu_rdata,
        input  mem_addr, mem_en, mem_wr, mem_rburst, mem_wburst, mem_wdata,
        output mem_rdy, mem_rdata, mem_rdata0, mem_rdata_load,
        input  hit_count, miss_count
    );
endinterface

`default_nettype wire

// File: rtl/cache_6502_nway.sv
// ============================================================================
// Module   : cache_6502_nway
// Purpose  : N-way fully associative, write-through read cache between the
//            6502 core and the 24-bit memory port. Instruction-fetch misses
//            (and optionally data-read misses) fill a whole line by burst;
//            other misses and all writes go straight through to memory.
//            Write hits update the cached byte in place. A flush pulse
//            invalidates every line. Read hits/misses are counted
//            (saturating at 16'hFFFF).
// Ports    : clk          clock, all state on the rising edge
//            rst_n        asynchronous active-low reset
//            bus.slave    flush, cpu_* request/response, mem_* port,
//                         hit_count / miss_count
// Params   : WAYS (2..8), LINE_BYTES (4..64, power of two),
//            DATA_ALLOC (0: only fetch misses fill), MEM_HI (mem_addr[23:16])
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_6502_nway #(
    parameter int         WAYS       = 2,
    parameter int         LINE_BYTES = 16,
    parameter int         DATA_ALLOC = 0,
    parameter logic [7:0] MEM_HI     = 8'h00
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    cache_6502_nway_if.slave    bus
);

    localparam int c_OFF_W = $clog2(LINE_BYTES);
    localparam int c_TAG_W = 16 - c_OFF_W;
    localparam int c_PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FILL     = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0]         r_data [WAYS][LINE_BYTES];
    logic [c_TAG_W-1:0] r_tag  [WAYS];
    logic [WAYS-1:0]    r_valid;
    logic [c_PTR_W-1:0] r_victim;
    logic [c_OFF_W-1:0] r_fill_off;
    logic [c_OFF_W-1:0] r_req_off;
    logic               r_flush_pend;
    logic [7:0]         r_rdata;
    logic [15:0]        r_hit_count;
    logic [15:0]        r_miss_count;

    // ------------------------------------------------------------------
    // Address split and hit detection
    // ------------------------------------------------------------------
    logic [c_TAG_W-1:0] w_cpu_tag;
    logic [c_OFF_W-1:0] w_cpu_off;
    logic [WAYS-1:0]    w_hit_vec;
    logic               w_hit;
    logic [c_PTR_W-1:0] w_hit_idx;
    logic [7:0]         w_hit_byte;
    logic [c_PTR_W-1:0] w_victim_next;
    logic               w_fill_last;

    assign w_cpu_tag = bus.cpu_addr[15:c_OFF_W];
    assign w_cpu_off = bus.cpu_addr[c_OFF_W-1:0];

    for (genvar g = 0; g < WAYS; g++) begin : g_hit
        assign w_hit_vec[g] = r_valid[g] && (r_tag[g] == w_cpu_tag);
    end

    assign w_hit = |w_hit_vec;

    // Descending scan so the lowest-index matching way ends up selected.
    always_comb begin
        w_hit_idx = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) begin
                w_hit_idx = c_PTR_W'(w);
            end
        end
    end

    assign w_hit_byte    = r_data[w_hit_idx][w_cpu_off];
    assign w_victim_next = (r_victim == c_PTR_W'(WAYS - 1)) ? '0 : r_victim + c_PTR_W'(1);
    assign w_fill_last   = (r_fill_off == c_OFF_W'(LINE_BYTES - 1));

    // A well-formed fill never creates a duplicate tag; two matches means
    // the tag store has been corrupted.
    a_single_hit: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_hit_vec));

    // ------------------------------------------------------------------
    // FSM next state and bus outputs
    // ------------------------------------------------------------------
    logic        w_cpu_rdy;
    logic        w_mem_en;
    logic        w_mem_rburst;
    logic [23:0] w_mem_addr;
    logic        w_rd_hit;
    logic        w_rd_miss;
    logic        w_alloc;
    logic        w_wr_acc;
    logic        w_load;

    assign w_load = bus.mem_rdata_load;

    always_comb begin
        w_next_state = r_state;
        w_cpu_rdy    = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_rburst = 1'b0;
        w_mem_addr   = {MEM_HI, bus.cpu_addr};
        w_rd_hit     = 1'b0;
        w_rd_miss    = 1'b0;
        w_alloc      = 1'b0;
        w_wr_acc     = 1'b0;

        case (r_state)
            ST_READY: begin
                // A flush wins over a concurrent access; the CPU sees
                // cpu_rdy=0 and simply retries.
                if (bus.flush) begin
                    w_next_state = ST_FLUSH;
                end else begin
                    w_cpu_rdy = 1'b1;
                    if (bus.cpu_en) begin
                        if (bus.cpu_wr) begin
                            w_wr_acc     = 1'b1;
                            w_mem_en     = 1'b1;
                            w_next_state = ST_MEM_WAIT;
                        end else if (w_hit) begin
                            w_rd_hit = 1'b1;
                        end else begin
                            w_rd_miss = 1'b1;
                            w_mem_en  = 1'b1;
                            if (bus.cpu_iread || (DATA_ALLOC != 0)) begin
                                w_alloc      = 1'b1;
                                w_mem_rburst = 1'b1;
                                w_mem_addr   = {MEM_HI, w_cpu_tag, {c_OFF_W{1'b0}}};
                                w_next_state = ST_FILL;
                            end else begin
                                w_next_state = ST_MEM_WAIT;
                            end
                        end
                    end
                end
            end

            ST_MEM_WAIT: begin
                w_mem_en = 1'b1;
                if (w_load) begin
                    w_next_state = (r_flush_pend || bus.flush) ? ST_FLUSH : ST_READY;
                end
            end

            ST_FILL: begin
                w_mem_addr = {MEM_HI, r_tag[r_victim], {c_OFF_W{1'b0}}};
                // The burst is already committed; the request is released
                // while the last byte is still on its way.
                if (!w_fill_last) begin
                    w_mem_en     = 1'b1;
                    w_mem_rburst = 1'b1;
                end
                if (w_load && w_fill_last) begin
                    w_next_state = (r_flush_pend || bus.flush) ? ST_FLUSH : ST_READY;
                end
            end

            ST_FLUSH: begin
                w_next_state = ST_READY;
            end

            default: begin
                w_next_state = ST_READY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control state (asynchronous reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_READY;
            r_valid      <= '0;
            r_victim     <= '0;
            r_fill_off   <= '0;
            r_req_off    <= '0;
            r_flush_pend <= 1'b0;
            r_rdata      <= 8'h00;
            r_hit_count  <= 16'h0000;
            r_miss_count <= 16'h0000;
        end else begin
            r_state <= w_next_state;

            // Flush requests that arrive mid-transaction are remembered
            // and executed once the transaction has returned.
            if ((r_state == ST_MEM_WAIT) || (r_state == ST_FILL)) begin
                if (bus.flush) begin
                    r_flush_pend <= 1'b1;
                end
            end else if (r_state == ST_FLUSH) begin
                r_flush_pend <= 1'b0;
                r_valid      <= '0;
            end

            if (w_rd_hit) begin
                r_rdata <= w_hit_byte;
                // Never pick the line just used as the next victim.
                if (w_hit_idx == r_victim) begin
                    r_victim <= w_victim_next;
                end
            end

            if (w_alloc) begin
                r_valid[r_victim] <= 1'b0;
                r_req_off         <= w_cpu_off;
                r_fill_off        <= '0;
            end

            if ((r_state == ST_MEM_WAIT) && w_load && !bus.cpu_wr) begin
                r_rdata <= bus.mem_rdata0;
            end

            if ((r_state == ST_FILL) && w_load) begin
                if (r_fill_off == r_req_off) begin
                    r_rdata <= bus.mem_rdata0;
                end
                if (w_fill_last) begin
                    r_valid[r_victim] <= 1'b1;
                    r_fill_off        <= '0;
                    r_victim          <= w_victim_next;
                end else begin
                    r_fill_off <= r_fill_off + c_OFF_W'(1);
                end
            end

            if (w_rd_hit && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (w_rd_miss && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag and data arrays (no reset; qualified by r_valid)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[r_victim] <= w_cpu_tag;
        end
        if ((r_state == ST_FILL) && w_load) begin
            r_data[r_victim][r_fill_off] <= bus.mem_rdata0;
        end
        // Write-through with in-place update of a cached byte.
        if (w_wr_acc && w_hit) begin
            r_data[w_hit_idx][w_cpu_off] <= bus.cpu_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cpu_rdy    = w_cpu_rdy;
    assign bus.cpu_rdata  = r_rdata;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_en     = w_mem_en;
    assign bus.mem_wr     = bus.cpu_wr;
    assign bus.mem_rburst = w_mem_rburst;
    assign bus.mem_wburst = 1'b0;
    assign bus.mem_wdata  = bus.cpu_wdata;
    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;

    // Reserved memory-side inputs, not used by this cache.
    logic w_unused_mem;
    assign w_unused_mem = &{1'b0, bus.mem_rdy, bus.mem_rdata};

endmodule

`default_nettype wire

// File: tb/tb_cache_6502_nway.sv
// ============================================================================
// Module   : tb_cache_6502_nway
// Purpose  : Self-checking bench for cache_6502_nway (WAYS=2, LINE_BYTES=16).
//            A second instance with DATA_ALLOC=1 shares the inputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_6502_nway;

    localparam int LB       = 16;
    localparam int K_HIT    = 0;
    localparam int K_FILL   = 1;
    localparam int K_SINGLE = 2;
    localparam int K_WRITE  = 3;

    logic clk;
    logic rst_n;

    cache_6502_nway_if bus0 ();
    cache_6502_nway_if bus1 ();

    cache_6502_nway #(.WAYS(2), .LINE_BYTES(LB), .DATA_ALLOC(0), .MEM_HI(8'h00)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    cache_6502_nway #(.WAYS(2), .LINE_BYTES(LB), .DATA_ALLOC(1), .MEM_HI(8'h00)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    assign bus0.mem_rdy        = 1'b0;
    assign bus0.mem_rdata      = 8'h00;
    assign bus1.flush          = bus0.flush;
    assign bus1.cpu_addr       = bus0.cpu_addr;
    assign bus1.cpu_en         = bus0.cpu_en;
    assign bus1.cpu_wr         = bus0.cpu_wr;
    assign bus1.cpu_iread      = bus0.cpu_iread;
    assign bus1.cpu_wdata      = bus0.cpu_wdata;
    assign bus1.mem_rdy        = 1'b0;
    assign bus1.mem_rdata      = 8'h00;
    assign bus1.mem_rdata0     = bus0.mem_rdata0;
    assign bus1.mem_rdata_load = bus0.mem_rdata_load;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem_model [0:65535];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        chk_data;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic        iread;
        logic [7:0]  wdata;
        int          kind;
        logic [7:0]  exp_data;
    } vec_t;
    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One CPU access plus the memory side of it. Memory data comes from
    // mem_model; writes update mem_model when acknowledged.
    task automatic access(input logic [15:0] addr, input logic wr, input logic iread,
                          input logic [7:0] wdata, input int kind, input logic [7:0] exp_data,
                          input int flush_at, input string tag);
        int          lat;
        int          nloads;
        logic [15:0] base;
        sb_t         e;
        @(negedge clk);
        bus0.cpu_addr  = addr;
        bus0.cpu_wr    = wr;
        bus0.cpu_iread = iread;
        bus0.cpu_wdata = wdata;
        bus0.cpu_en    = 1'b1;
        e.addr = addr; e.data = exp_data; e.chk_data = !wr;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        chk($sformatf("%s rdy-after-accept", tag), bus0.cpu_rdy, (kind == K_HIT) ? 1 : 0);
        if (kind != K_HIT && !bus0.cpu_rdy) begin
            base = (kind == K_FILL) ? {addr[15:4], 4'h0} : addr;
            chk($sformatf("%s mem_en", tag), bus0.mem_en, 1);
            chk($sformatf("%s mem_rburst", tag), bus0.mem_rburst, (kind == K_FILL) ? 1 : 0);
            chk($sformatf("%s mem_wr", tag), bus0.mem_wr, wr);
            chk($sformatf("%s mem_addr", tag), bus0.mem_addr, {8'h00, base});
            if (wr) chk($sformatf("%s mem_wdata", tag), bus0.mem_wdata, wdata);
            nloads = (kind == K_FILL) ? LB : 1;
            for (int i = 0; i < nloads; i++) begin
                if (kind == K_FILL && i == LB - 1)
                    chk($sformatf("%s mem_en-drop", tag), {bus0.mem_en, bus0.mem_rburst}, 0);
                bus0.flush          = (i == flush_at);
                bus0.mem_rdata_load = 1'b1;
                if (wr) begin
                    bus0.mem_rdata0 = 8'h00;
                    mem_model[addr] = wdata;
                end else begin
                    bus0.mem_rdata0 = mem_model[base + 16'(i)];
                end
                @(negedge clk);
                lat++;
            end
            bus0.mem_rdata_load = 1'b0;
            bus0.flush          = 1'b0;
        end
        bus0.cpu_en = 1'b0;
        for (int t = 0; t < 8 && !bus0.cpu_rdy; t++) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s done", tag), bus0.cpu_rdy, 1);
        e = sb_q.pop_front();
        if (e.chk_data) chk($sformatf("%s rdata@%h", tag, e.addr), bus0.cpu_rdata, e.data);
        if (kind == K_HIT) chk($sformatf("%s latency", tag), lat, 1);
        if (kind == K_FILL) chk($sformatf("%s latency", tag), lat, LB + 1 + ((flush_at >= 0) ? 1 : 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] av;
            av = 16'(a);
            mem_model[a] = av[7:0] ^ av[15:8];
        end

        // addr, wr, iread, wdata, kind, expected rdata
        vecs[0]  = '{16'h1234, 1'b0, 1'b1, 8'h00, K_FILL,   8'h26};
        vecs[1]  = '{16'h123F, 1'b0, 1'b1, 8'h00, K_HIT,    8'h2D};
        vecs[2]  = '{16'h1000, 1'b0, 1'b1, 8'h00, K_FILL,   8'h10};
        vecs[3]  = '{16'h2000, 1'b0, 1'b1, 8'h00, K_FILL,   8'h20};
        vecs[4]  = '{16'h1000, 1'b0, 1'b1, 8'h00, K_HIT,    8'h10};
        vecs[5]  = '{16'h3000, 1'b0, 1'b1, 8'h00, K_FILL,   8'h30};
        vecs[6]  = '{16'h1008, 1'b0, 1'b1, 8'h00, K_HIT,    8'h18};
        vecs[7]  = '{16'h2004, 1'b0, 1'b1, 8'h00, K_FILL,   8'h24};
        vecs[8]  = '{16'h1005, 1'b1, 1'b0, 8'hA5, K_WRITE,  8'h00};
        vecs[9]  = '{16'h1005, 1'b0, 1'b1, 8'h00, K_HIT,    8'hA5};
        vecs[10] = '{16'h1006, 1'b0, 1'b0, 8'h00, K_HIT,    8'h16};
        vecs[11] = '{16'h4000, 1'b0, 1'b0, 8'h00, K_SINGLE, 8'h40};
        vecs[12] = '{16'h4000, 1'b0, 1'b0, 8'h00, K_SINGLE, 8'h40};
        vecs[13] = '{16'h5000, 1'b1, 1'b0, 8'h3C, K_WRITE,  8'h00};
        vecs[14] = '{16'h5000, 1'b0, 1'b1, 8'h00, K_FILL,   8'h3C};
        vecs[15] = '{16'h1005, 1'b0, 1'b1, 8'h00, K_HIT,    8'hA5};

        bus0.flush = 1'b0; bus0.cpu_addr = 16'h0000; bus0.cpu_en = 1'b0;
        bus0.cpu_wr = 1'b0; bus0.cpu_iread = 1'b0; bus0.cpu_wdata = 8'h00;
        bus0.mem_rdata0 = 8'h00; bus0.mem_rdata_load = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset cpu_rdy", bus0.cpu_rdy, 1);
        chk("reset mem_en", bus0.mem_en, 0);
        chk("reset mem_rburst", bus0.mem_rburst, 0);
        chk("reset cpu_rdata", bus0.cpu_rdata, 0);
        chk("reset hit_count", bus0.hit_count, 0);
        chk("reset miss_count", bus0.miss_count, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            access(vecs[i].addr, vecs[i].wr, vecs[i].iread, vecs[i].wdata,
                   vecs[i].kind, vecs[i].exp_data, -1, $sformatf("vec%0d", i));
        chk("table hit_count", bus0.hit_count, 6);
        chk("table miss_count", bus0.miss_count, 8);

        // Flush in READY beats a concurrent read hit.
        @(negedge clk);
        bus0.cpu_addr = 16'h1005; bus0.cpu_wr = 1'b0; bus0.cpu_iread = 1'b1;
        bus0.cpu_en = 1'b1; bus0.flush = 1'b1;
        #1 chk("flush-ready rdy", bus0.cpu_rdy, 0);
        @(negedge clk);
        bus0.flush = 1'b0; bus0.cpu_en = 1'b0;
        chk("flush-state rdy", bus0.cpu_rdy, 0);
        @(negedge clk);
        chk("flush-done rdy", bus0.cpu_rdy, 1);
        chk("flush hit_count", bus0.hit_count, 6);
        access(16'h1005, 1'b0, 1'b1, 8'h00, K_FILL, 8'hA5, -1, "post-flush");

        // Flush during a fill: fill completes, then everything is invalid.
        access(16'h6000, 1'b0, 1'b1, 8'h00, K_FILL, 8'h60, 5, "fill-flush");
        access(16'h6000, 1'b0, 1'b1, 8'h00, K_FILL, 8'h60, -1, "refill");
        access(16'h1005, 1'b0, 1'b1, 8'h00, K_FILL, 8'hA5, -1, "refill2");
        chk("pre-sat miss_count", bus0.miss_count, 12);

        // Back-to-back hits past the counter limit.
        @(negedge clk);
        bus0.cpu_addr = 16'h1005; bus0.cpu_iread = 1'b1; bus0.cpu_en = 1'b1;
        repeat (65540) @(negedge clk);
        bus0.cpu_en = 1'b0;
        @(negedge clk);
        chk("sat hit_count", bus0.hit_count, 16'hFFFF);
        chk("sat miss_count", bus0.miss_count, 12);
        chk("sat rdata", bus0.cpu_rdata, 8'hA5);

        // DATA_ALLOC: same data-read miss, single access vs. line fill.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus0.cpu_addr = 16'h4008; bus0.cpu_wr = 1'b0; bus0.cpu_iread = 1'b0; bus0.cpu_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("da0 mem_rburst", bus0.mem_rburst, 0);
        chk("da0 mem_addr", bus0.mem_addr, 24'h004008);
        chk("da1 mem_en", bus1.mem_en, 1);
        chk("da1 mem_rburst", bus1.mem_rburst, 1);
        chk("da1 mem_addr", bus1.mem_addr, 24'h004000);
        bus0.mem_rdata_load = 1'b1; bus0.mem_rdata0 = mem_model[16'h4008];
        @(negedge clk);
        bus0.mem_rdata_load = 1'b0; bus0.cpu_en = 1'b0;
        chk("da0 rdy", bus0.cpu_rdy, 1);
        chk("da0 rdata", bus0.cpu_rdata, 8'h48);
        access(16'h4008, 1'b0, 1'b0, 8'h00, K_SINGLE, 8'h48, -1, "da0 reread");

        // Reset in the middle of a fill.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus0.cpu_addr = 16'h7003; bus0.cpu_iread = 1'b1; bus0.cpu_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus0.mem_rdata_load = 1'b1;
            bus0.mem_rdata0 = mem_model[16'h7000 + 16'(i)];
            @(negedge clk);
        end
        bus0.mem_rdata_load = 1'b0; bus0.cpu_en = 1'b0;
        chk("midfill mem_en before reset", bus0.mem_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midfill mem_en after reset", bus0.mem_en, 0);
        chk("midfill rburst after reset", bus0.mem_rburst, 0);
        chk("midfill rdy after reset", bus0.cpu_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midfill miss_count", bus0.miss_count, 0);
        access(16'h7003, 1'b0, 1'b1, 8'h00, K_FILL, 8'h73, -1, "post-reset");
        chk("post-reset miss_count", bus0.miss_count, 1);
        access(16'h7003, 1'b0, 1'b1, 8'h00, K_HIT, 8'h73, -1, "post-reset hit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
